// File: rtl/serdes_pkg.sv
// Shared constants, lane-word select encoding and bit-counter sizing for serdes_n_to_1_soft.
// TRAIN_WORD_DEF is only consumed when SERDES_TRAIN_EN is defined.
package serdes_pkg;

  localparam logic [15:0] IDLE_WORD_DEF  = 16'h0354;
  localparam logic [15:0] TRAIN_WORD_DEF = 16'h00F8;

  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 16;
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 8;

  typedef enum logic [1:0] {
    SEL_IDLE   = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BYPASS = 2'd2,
    SEL_TRAIN  = 2'd3
  } word_sel_e;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serdes_n_to_1_soft_if.sv
// Word handshake between a line encoder (master) and the soft serializer (slave).
// The train signal exists only when SERDES_TRAIN_EN is defined.
interface serdes_n_to_1_soft_if #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4
);

  logic [CHANNELS*WIDTH-1:0] datain;
  logic                      data_valid;
  logic                      data_ready;
`ifdef SERDES_TRAIN_EN
  logic                      train;

  modport master (output datain, output data_valid, output train, input data_ready);
  modport slave  (input datain, input data_valid, input train, output data_ready);
`else
  modport master (output datain, output data_valid, input data_ready);
  modport slave  (input datain, input data_valid, output data_ready);
`endif

endinterface

// File: rtl/serdes_shift_lane.sv
// One serial lane: parallel load on the word boundary, otherwise shift right, LSB out.
// Identical in both SERDES_TRAIN_EN builds; word selection lives in the top.
module serdes_shift_lane #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  output logic             sout
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= word;
    end else begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign sout = shreg[0];

endmodule

// File: rtl/serdes_n_to_1_soft.sv
// N:1 fabric serializer: CHANNELS lanes of WIDTH-bit words, one-word holding buffer,
// idle insertion on underrun. Define SERDES_TRAIN_EN to add the train port and TRAIN_WORD.
module serdes_n_to_1_soft
  import serdes_pkg::*;
#(
  parameter int          WIDTH      = 10,
  parameter int          CHANNELS   = 4,
`ifdef SERDES_TRAIN_EN
  parameter logic [15:0] TRAIN_WORD = TRAIN_WORD_DEF,
`endif
  parameter logic [15:0] IDLE_WORD  = IDLE_WORD_DEF
) (
  input  logic                ioclk,
  input  logic                reset,
  serdes_n_to_1_soft_if.slave ifc,
  output logic                serdesstrobe,
  output logic [CHANNELS-1:0] iob_data_out,
  output logic                underrun
);

  localparam int             CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] IDLE_W = IDLE_WORD[WIDTH-1:0];

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_cfg
      $error("serdes_n_to_1_soft: WIDTH or CHANNELS outside the supported range");
    end
  endgenerate

  logic [CW-1:0]             bitcnt;
  logic                      load;
  logic                      train_now;
  logic                      accept;
  logic                      store;
  logic                      hold_full;
  logic [CHANNELS*WIDTH-1:0] hold;
  word_sel_e                 sel;

`ifdef SERDES_TRAIN_EN
  assign train_now = ifc.train;
`else
  assign train_now = 1'b0;
`endif

  // Training blocks the hold from draining, so only an empty hold can accept then.
  assign load           = (bitcnt == LAST);
  assign ifc.data_ready = !hold_full || (load && !train_now);
  assign accept         = ifc.data_valid && ifc.data_ready;

  always_comb begin
    sel = SEL_IDLE;
    if (train_now) begin
      sel = SEL_TRAIN;
    end else if (hold_full) begin
      sel = SEL_HOLD;
    end else if (accept) begin
      sel = SEL_BYPASS;
    end
  end

  // Every accepted word lands in hold unless it goes straight to the lanes.
  assign store = accept && !(load && sel == SEL_BYPASS);

  // ---- control: bit counter, hold occupancy, strobe, sticky underrun ----
  always_ff @(posedge ioclk) begin
    if (reset) begin
      bitcnt       <= LAST;
      hold_full    <= 1'b0;
      serdesstrobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      bitcnt       <= load ? '0 : bitcnt + CW'(1);
      serdesstrobe <= load;
      if (load && sel == SEL_IDLE) begin
        underrun <= 1'b1;
      end
      if (load && sel == SEL_HOLD) begin
        hold_full <= store;
      end else if (store) begin
        hold_full <= 1'b1;
      end
    end
  end

  // ---- data: holding buffer, validity tracked by hold_full ----
  always_ff @(posedge ioclk) begin
    if (store) begin
      hold <= ifc.datain;
    end
  end

  // ---- lanes: word select and shift registers ----
  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    logic [WIDTH-1:0] word;

    always_comb begin
      word = IDLE_W;
      case (sel)
        SEL_HOLD:   word = hold[n*WIDTH +: WIDTH];
        SEL_BYPASS: word = ifc.datain[n*WIDTH +: WIDTH];
`ifdef SERDES_TRAIN_EN
        SEL_TRAIN:  word = TRAIN_WORD[WIDTH-1:0];
`endif
        default:    word = IDLE_W;
      endcase
    end

    serdes_shift_lane #(.WIDTH(WIDTH)) u_lane (
      .clk  (ioclk),
      .rst  (reset),
      .load (load),
      .word (word),
      .sout (iob_data_out[n])
    );
  end

endmodule

// File: tb/tb_serdes_n_to_1_soft.sv
// Bench for serdes_n_to_1_soft: table vectors, corner sequences and random traffic
// against a queue-based reference model. Covers SERDES_TRAIN_EN when defined.
module tb_serdes_n_to_1_soft;

  localparam int WIDTH    = 10;
  localparam int CHANNELS = 4;
  localparam int BW       = WIDTH * CHANNELS;
  localparam logic [WIDTH-1:0] IDLE  = 10'h354;
  localparam logic [WIDTH-1:0] TRAIN = 10'h0F8;

  typedef logic [BW-1:0] bus_t;

  logic                ioclk = 1'b0;
  logic                reset = 1'b1;
  logic                serdesstrobe;
  logic                underrun;
  logic [CHANNELS-1:0] iob_data_out;
  logic                train_b = 1'b0;

  serdes_n_to_1_soft_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) ifc ();

`ifdef SERDES_TRAIN_EN
  assign ifc.train = train_b;
`endif

  serdes_n_to_1_soft #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .ioclk        (ioclk),
    .reset        (reset),
    .ifc          (ifc),
    .serdesstrobe (serdesstrobe),
    .iob_data_out (iob_data_out),
    .underrun     (underrun)
  );

  always #5 ioclk = ~ioclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words waiting for the wire, the word on the wire, bit position.
  bus_t pend[$];
  bus_t cur_m;
  int   cnt_m;
  int   pos_m;
  logic under_m;
  logic strobe_m;
  logic last_acc;

  function automatic bus_t rep(input logic [WIDTH-1:0] w);
    bus_t r;
    for (int n = 0; n < CHANNELS; n++) r[n*WIDTH +: WIDTH] = w;
    return r;
  endfunction

  function automatic bus_t rand_bus();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[BW-1:0];
  endfunction

  function automatic logic model_ready();
    return (pend.size() == 0) || (cnt_m == 0 && !train_b);
  endfunction

  function automatic logic [CHANNELS-1:0] exp_out();
    logic [CHANNELS-1:0] r;
    for (int n = 0; n < CHANNELS; n++) r[n] = cur_m[n*WIDTH + pos_m];
    return r;
  endfunction

  task automatic model_reset();
    cur_m    = '0;
    pend.delete();
    cnt_m    = 0;
    pos_m    = 0;
    under_m  = 1'b0;
    strobe_m = 1'b0;
  endtask

  task automatic model_edge(input logic acc, input bus_t din);
    if (reset) begin
      model_reset();
      return;
    end
    strobe_m = (cnt_m == 0);
    if (cnt_m == 0) begin
      if (train_b) begin
        cur_m = rep(TRAIN);
        if (acc) pend.push_back(din);
      end else if (pend.size() > 0) begin
        cur_m = pend.pop_front();
        if (acc) pend.push_back(din);
      end else if (acc) begin
        cur_m = din;
      end else begin
        cur_m   = rep(IDLE);
        under_m = 1'b1;
      end
    end else if (acc) begin
      pend.push_back(din);
    end
    pos_m = cnt_m;
    cnt_m = (cnt_m + 1) % WIDTH;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check ready before the edge, advance model, check outputs at negedge.
  task automatic cycle();
    logic rdy;
    bus_t din;
    #1;
    rdy = model_ready();
    check("data_ready", {63'd0, ifc.data_ready}, {63'd0, rdy});
    last_acc = ifc.data_valid && rdy && !reset;
    din = ifc.datain;
    @(posedge ioclk);
    model_edge(last_acc, din);
    @(negedge ioclk);
    check("iob_data_out", {60'd0, iob_data_out}, {60'd0, exp_out()});
    check("serdesstrobe", {63'd0, serdesstrobe}, {63'd0, strobe_m});
    check("underrun", {63'd0, underrun}, {63'd0, under_m});
  endtask

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] word;
    logic [0:WIDTH-1] seq;
    logic             under;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w;
    bus_t             wd;
    int               k;
    int               rdy_cnt;

    tbl[0] = '{1'b1, 10'h2AA, 10'b0101010101, 1'b0};
    tbl[1] = '{1'b1, 10'h155, 10'b1010101010, 1'b0};
    tbl[2] = '{1'b0, 10'h000, 10'b0010101011, 1'b1};
    tbl[3] = '{1'b1, 10'h0F3, 10'b1100111100, 1'b1};

    ifc.data_valid = 1'b0;
    ifc.datain     = '0;
    reset          = 1'b1;
    model_reset();
    @(posedge ioclk);
    @(negedge ioclk);

    // Reset held: outputs quiet, ready asserted.
    repeat (5) cycle();
    check("rst_iob", {60'd0, iob_data_out}, 64'd0);
    check("rst_strobe", {63'd0, serdesstrobe}, 64'd0);
    check("rst_underrun", {63'd0, underrun}, 64'd0);
    check("rst_ready", {63'd0, ifc.data_ready}, 64'd1);

    // Table: one word per load edge, lane 0 compared bit by bit.
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wd = rand_bus();
      wd[WIDTH-1:0] = tbl[r].word;
      ifc.datain     = wd;
      ifc.data_valid = tbl[r].valid;
      for (int i = 0; i < WIDTH; i++) begin
        cycle();
        ifc.data_valid = 1'b0;
        check($sformatf("tbl%0d_bit%0d", r, i), {63'd0, iob_data_out[0]}, {63'd0, tbl[r].seq[i]});
        check($sformatf("tbl%0d_strobe%0d", r, i), {63'd0, serdesstrobe}, {63'd0, (i == 0)});
        check($sformatf("tbl%0d_under%0d", r, i), {63'd0, underrun}, {63'd0, tbl[r].under});
      end
    end

    // Sustained valid with a counting pattern; ready duty once the hold is full.
    k = 0;
    rdy_cnt = 0;
    ifc.data_valid = 1'b1;
    for (int n = 0; n < CHANNELS; n++) ifc.datain[n*WIDTH +: WIDTH] = WIDTH'(k * CHANNELS + n);
    for (int c = 0; c < 80; c++) begin
      cycle();
      if (last_acc) begin
        k++;
        for (int n = 0; n < CHANNELS; n++) ifc.datain[n*WIDTH +: WIDTH] = WIDTH'(k * CHANNELS + n);
      end
      if (c >= 30 && ifc.data_ready) rdy_cnt++;
    end
    check("ready_duty", 64'(rdy_cnt), 64'd5);

    // Reset while bit 4 is on the wire and the hold is full.
    for (int g = 0; g < 2 * WIDTH && cnt_m != 5; g++) cycle();
    ifc.data_valid = 1'b0;
    reset = 1'b1;
    cycle();
    check("midrst_iob", {60'd0, iob_data_out}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cycle();
      w[i] = iob_data_out[0];
      if (i == 0) begin
        check("midrst_under", {63'd0, underrun}, 64'd1);
        check("midrst_strobe", {63'd0, serdesstrobe}, 64'd1);
      end
    end
    check("midrst_word", {54'd0, w}, {54'd0, IDLE});

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      ifc.data_valid = ($urandom_range(0, 3) != 0);
      ifc.datain     = rand_bus();
      reset          = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0;
    ifc.data_valid = 1'b0;

`ifdef SERDES_TRAIN_EN
    // Train for 30 cycles with a word parked in hold, then the held word.
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    train_b = 1'b1;
    wd = rand_bus();
    ifc.datain = wd;
    ifc.data_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      ifc.data_valid = 1'b0;
      w[c % WIDTH] = iob_data_out[0];
      if (c % WIDTH == WIDTH - 1) check($sformatf("train_word%0d", c / WIDTH), {54'd0, w}, {54'd0, TRAIN});
    end
    train_b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cycle();
      w[i] = iob_data_out[0];
    end
    check("train_held_word", {54'd0, w}, {54'd0, wd[WIDTH-1:0]});
    check("train_underrun", {63'd0, underrun}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
